// File: rtl/hv_pkg.sv
// Shared definitions for the hypervector core.
//   - op_e       : 4-bit instruction opcode
//   - field positions of op / rd / rs inside the 16-bit instruction word
//   - sat_max()  : largest magnitude a signed bundling counter may reach
//   - inst_op / inst_rd / inst_rs : field extractors
package hv_pkg;

  localparam int INST_W = 16;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 10;
  localparam int RS_MSB = 1;
  localparam int RS_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_LOAD    = 4'd1,
    OP_LROR    = 4'd2,
    OP_LROL    = 4'd3,
    OP_LXOR    = 4'd4,
    OP_ROR     = 4'd5,
    OP_ROL     = 4'd6,
    OP_XOR     = 4'd7,
    OP_MOVE    = 4'd8,
    OP_BUND    = 4'd9,
    OP_MAJ     = 4'd10,
    OP_CLR     = 4'd11,
    OP_STORE   = 4'd12,
    OP_LASTORE = 4'd13,
    OP_RSV14   = 4'd14,
    OP_RSV15   = 4'd15
  } op_e;

  // Counters saturate symmetrically, so the most negative code is never used.
  function automatic int sat_max(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  function automatic op_e inst_op(input logic [INST_W-1:0] i);
    return op_e'(i[OP_MSB:OP_LSB]);
  endfunction

  function automatic logic [1:0] inst_rd(input logic [INST_W-1:0] i);
    return i[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [1:0] inst_rs(input logic [INST_W-1:0] i);
    return i[RS_MSB:RS_LSB];
  endfunction

endpackage

// File: rtl/hv_bundle_acc.sv
// Bank of D signed saturating bundling counters.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears counters)
//   bund         : add +1 / -1 per bit according to vec
//   clr          : zero all counters
//   vec [D]      : hypervector being bundled
//   tie [D]      : value used for bits whose counter is exactly zero
//   maj [D]      : majority vector (c>0 -> 1, c<0 -> 0, c==0 -> tie)
module hv_bundle_acc
  import hv_pkg::*;
#(
  parameter int D     = 1024,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bund,
  input  logic         clr,
  input  logic [D-1:0] vec,
  input  logic [D-1:0] tie,
  output logic [D-1:0] maj
);

  localparam logic signed [CNT_W-1:0] C_MAX = CNT_W'(sat_max(CNT_W));
  localparam logic signed [CNT_W-1:0] C_MIN = -C_MAX;
  localparam logic signed [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic signed [CNT_W-1:0] cnt [D];

  // NOTE: state registers take non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < D; i++) cnt[i] <= '0;
    end else if (bund) begin
      for (int i = 0; i < D; i++) begin
        if (vec[i] && (cnt[i] != C_MAX))       cnt[i] <= cnt[i] + C_ONE;
        else if (!vec[i] && (cnt[i] != C_MIN)) cnt[i] <= cnt[i] - C_ONE;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    maj = '0;
    for (int i = 0; i < D; i++) begin
      if (cnt[i] == '0) maj[i] = tie[i];
      else              maj[i] = ~cnt[i][CNT_W-1];
    end
  end

endmodule

// File: rtl/hv_core_multi.sv
// Hypervector processing core: item memory, 4-entry register file, bundling
// counters and a result stream, driven by a 16-bit instruction stream.
// Pipeline: stage 1 accepts an instruction and reads the item memory into a
// register; stage 2 executes and updates registers / counters / output.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   gen, update_item, item_a,
//   rand_num                        : item-memory write port
//   inst_valid, inst, inst_ready    : instruction handshake
//   out_valid, out_last, out_data,
//   out_ready                       : result handshake
module hv_core_multi
  import hv_pkg::*;
#(
  parameter int D      = 1024,
  parameter int ADDR_W = 10,
  parameter int NREG   = 4,
  parameter int SHIFT  = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gen,
  input  logic              update_item,
  input  logic [ADDR_W-1:0] item_a,
  input  logic [D-1:0]      rand_num,
  input  logic              inst_valid,
  input  logic [INST_W-1:0] inst,
  output logic              inst_ready,
  output logic              out_valid,
  output logic              out_last,
  output logic [D-1:0]      out_data,
  input  logic              out_ready
);

  function automatic logic [D-1:0] ror_f(input logic [D-1:0] x);
    return (x >> SHIFT) | (x << (D - SHIFT));
  endfunction

  function automatic logic [D-1:0] rol_f(input logic [D-1:0] x);
    return (x << SHIFT) | (x >> (D - SHIFT));
  endfunction

  // Item memory and its registered read port.
  logic [D-1:0] mem [2**ADDR_W];
  logic [D-1:0] mem_q;

  // Execute-stage instruction register.
  logic       ex_valid;
  op_e        ex_op;
  logic [1:0] ex_rd;
  logic [1:0] ex_rs;

  logic [D-1:0] regs [NREG];
  logic [D-1:0] rd_val;
  logic [D-1:0] rs_val;
  logic [D-1:0] maj_vec;

  logic         stall;
  logic         accept;
  logic         exec;
  logic         wr_en;
  logic [D-1:0] wr_data;
  logic         bund_en;
  logic         clr_en;
  logic         store_en;
  logic         store_last;

  // A STORE cannot overwrite an output that the consumer has not taken yet.
  assign stall = ex_valid && ((ex_op == OP_STORE) || (ex_op == OP_LASTORE))
                 && out_valid && !out_ready;

  assign inst_ready = !rst && !gen && !stall;
  assign accept     = inst_valid && inst_ready;
  assign exec       = ex_valid && !stall;

  assign rd_val = regs[ex_rd];
  assign rs_val = regs[ex_rs];

  // NOTE: the item memory has no reset so it maps onto block RAM; its read
  // register is only consumed behind ex_valid, which is reset.
  always_ff @(posedge clk) begin
    if (gen && update_item) mem[item_a] <= rand_num;
    // Holding the read register during a stall keeps the data paired with
    // the instruction still waiting in the execute stage.
    if (!stall) mem_q <= mem[inst[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_op    <= OP_NOP;
      ex_rd    <= '0;
      ex_rs    <= '0;
    end else if (!stall) begin
      ex_valid <= accept;
      ex_op    <= inst_op(inst);
      ex_rd    <= inst_rd(inst);
      ex_rs    <= inst_rs(inst);
    end
  end

  always_comb begin
    wr_en      = 1'b0;
    wr_data    = '0;
    bund_en    = 1'b0;
    clr_en     = 1'b0;
    store_en   = 1'b0;
    store_last = 1'b0;
    if (exec) begin
      case (ex_op)
        OP_LOAD:    begin wr_en = 1'b1; wr_data = mem_q;           end
        OP_LROR:    begin wr_en = 1'b1; wr_data = ror_f(mem_q);    end
        OP_LROL:    begin wr_en = 1'b1; wr_data = rol_f(mem_q);    end
        OP_LXOR:    begin wr_en = 1'b1; wr_data = rd_val ^ mem_q;  end
        OP_ROR:     begin wr_en = 1'b1; wr_data = ror_f(rd_val);   end
        OP_ROL:     begin wr_en = 1'b1; wr_data = rol_f(rd_val);   end
        OP_XOR:     begin wr_en = 1'b1; wr_data = rd_val ^ rs_val; end
        OP_MOVE:    begin wr_en = 1'b1; wr_data = rs_val;          end
        OP_MAJ:     begin wr_en = 1'b1; wr_data = maj_vec;         end
        OP_BUND:    bund_en = 1'b1;
        OP_CLR:     clr_en  = 1'b1;
        OP_STORE:   store_en = 1'b1;
        OP_LASTORE: begin store_en = 1'b1; store_last = 1'b1; end
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[ex_rd] <= wr_data;
    end
  end

  // A new store wins over clearing the output that is being handed off.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (store_en) begin
      out_valid <= 1'b1;
      out_last  <= store_last;
      out_data  <= rd_val;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end
  end

  hv_bundle_acc #(
    .D     (D),
    .CNT_W (CNT_W)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .bund (bund_en),
    .clr  (clr_en),
    .vec  (rd_val),
    .tie  (rs_val),
    .maj  (maj_vec)
  );

endmodule

// File: tb/tb_hv_core_multi.sv
// Directed bench for hv_core_multi (D=16, SHIFT=1, CNT_W=4, ADDR_W=4).
// The stimulus pushes each expected result into a queue when it issues a
// STORE/LASTORE; a separate monitor pops and compares on every output
// handshake. Inputs change 1 time unit after the rising edge, and DUT
// outputs are sampled on the falling edge.
module tb_hv_core_multi;
  import hv_pkg::*;

  localparam int D      = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              gen = 1'b0;
  logic              update_item = 1'b0;
  logic [ADDR_W-1:0] item_a = '0;
  logic [D-1:0]      rand_num = '0;
  logic              inst_valid = 1'b0;
  logic [15:0]       inst = '0;
  logic              inst_ready;
  logic              out_valid;
  logic              out_last;
  logic [D-1:0]      out_data;
  logic              out_ready = 1'b1;

  hv_core_multi #(
    .D(D), .ADDR_W(ADDR_W), .NREG(4), .SHIFT(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .gen(gen), .update_item(update_item),
    .item_a(item_a), .rand_num(rand_num), .inst_valid(inst_valid),
    .inst(inst), .inst_ready(inst_ready), .out_valid(out_valid),
    .out_last(out_last), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [D-1:0] data;
    logic         last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one comparison per completed output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_last", 32'(out_last), 32'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input logic [ADDR_W-1:0] a, input logic [D-1:0] v);
    gen = 1'b1; update_item = 1'b1; item_a = a; rand_num = v;
    @(negedge clk);
    check("inst_ready_gen", 32'(inst_ready), 32'd0);
    tick();
    gen = 1'b0; update_item = 1'b0;
  endtask

  // Present one instruction and hold it until the DUT accepts it.
  task automatic issue(input logic [3:0] op, input logic [1:0] rd,
                       input logic [3:0] low);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    inst_valid = 1'b1;
    inst = {op, rd, 6'b0, low};
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = inst_ready;
      tick();
      n++;
    end
    inst_valid = 1'b0;
    if (!acc) check("issue_accept", 32'(acc), 32'd1);
  endtask

  task automatic store(input logic [1:0] rd, input logic last,
                       input logic [D-1:0] exp);
    exp_t e;
    e.data = exp;
    e.last = last;
    sb.push_back(e);
    issue(last ? OP_LASTORE : OP_STORE, rd, 4'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t_load;
    int n;

    // Reset state.
    repeat (2) tick();
    @(negedge clk);
    check("inst_ready_in_rst", 32'(inst_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("inst_ready_idle", 32'(inst_ready), 32'd1);
    tick();

    // Item memory contents.
    write_mem(4'd3,  16'h8001);
    write_mem(4'd5,  16'h0001);
    write_mem(4'd6,  16'h00FF);
    write_mem(4'd7,  16'h0F0F);
    write_mem(4'd8,  16'hFFFF);
    write_mem(4'd9,  16'h1234);
    write_mem(4'd10, 16'h0000);

    // LOAD then STORE: out_valid appears two edges after the LOAD accept edge,
    // i.e. in the third cycle after the acceptance cycle.
    issue(OP_LOAD, 2'd0, 4'd3);
    t_load = cyc;
    store(2'd0, 1'b0, 16'h8001);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("store_latency", 32'(cyc - t_load), 32'd2);
    tick();
    drain();

    // Rotates, loads with rotate/xor, register xor and move.
    issue(OP_LOAD, 2'd0, 4'd5);
    issue(OP_ROR,  2'd0, 4'd0);
    store(2'd0, 1'b0, 16'h8000);
    issue(OP_ROL,  2'd0, 4'd0);
    issue(OP_ROL,  2'd0, 4'd0);
    store(2'd0, 1'b0, 16'h0002);
    issue(OP_LROR, 2'd1, 4'd3);
    store(2'd1, 1'b0, 16'hC000);
    issue(OP_LROL, 2'd2, 4'd3);
    store(2'd2, 1'b0, 16'h0003);
    issue(OP_LXOR, 2'd2, 4'd6);
    store(2'd2, 1'b0, 16'h00FC);
    issue(OP_XOR,  2'd2, 4'd1);
    store(2'd2, 1'b0, 16'hC0FC);
    issue(OP_MOVE, 2'd3, 4'd2);
    store(2'd3, 1'b0, 16'hC0FC);
    drain();

    // Bundle FFFF, 00FF, 0F0F: counters +3/+1/+1/-1 per nibble -> 0FFF.
    issue(OP_CLR,  2'd0, 4'd0);
    issue(OP_LOAD, 2'd1, 4'd8);
    issue(OP_BUND, 2'd1, 4'd0);
    issue(OP_LOAD, 2'd1, 4'd6);
    issue(OP_BUND, 2'd1, 4'd0);
    issue(OP_LOAD, 2'd1, 4'd7);
    issue(OP_BUND, 2'd1, 4'd0);
    issue(OP_LOAD, 2'd2, 4'd10);
    issue(OP_MAJ,  2'd1, 4'd2);
    store(2'd1, 1'b0, 16'h0FFF);
    // All-zero counters: every bit comes from the tie register (r3=C0FC).
    issue(OP_CLR,  2'd0, 4'd0);
    issue(OP_MAJ,  2'd1, 4'd3);
    store(2'd1, 1'b0, 16'hC0FC);

    // Positive saturation at +7: 9 ups then 7 downs must land on exactly 0.
    issue(OP_CLR,  2'd0, 4'd0);
    issue(OP_LOAD, 2'd0, 4'd8);
    for (int i = 0; i < 9; i++) issue(OP_BUND, 2'd0, 4'd0);
    issue(OP_MAJ,  2'd3, 4'd2);
    store(2'd3, 1'b0, 16'hFFFF);
    for (int i = 0; i < 7; i++) issue(OP_BUND, 2'd2, 4'd0);
    issue(OP_MAJ,  2'd3, 4'd1);
    store(2'd3, 1'b0, 16'hC0FC);
    // Negative saturation at -7.
    issue(OP_CLR,  2'd0, 4'd0);
    for (int i = 0; i < 9; i++) issue(OP_BUND, 2'd2, 4'd0);
    for (int i = 0; i < 7; i++) issue(OP_BUND, 2'd0, 4'd0);
    issue(OP_MAJ,  2'd3, 4'd1);
    store(2'd3, 1'b0, 16'hC0FC);
    // Reserved and NOP opcodes leave state alone.
    issue(4'd14,  2'd0, 4'd3);
    issue(4'd15,  2'd0, 4'd3);
    issue(OP_NOP, 2'd0, 4'd3);
    store(2'd0, 1'b0, 16'hFFFF);
    drain();

    // Output back-pressure: STORE held, LASTORE waits in execute.
    out_ready = 1'b0;
    issue(OP_LOAD, 2'd0, 4'd9);
    store(2'd0, 1'b0, 16'h1234);
    store(2'd1, 1'b1, 16'hC0FC);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_inst_ready", 32'(inst_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", 32'(out_data), 32'h1234);
      check("stall_out_last", 32'(out_last), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    drain();
    repeat (2) tick();
    @(negedge clk);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_out_last", 32'(out_last), 32'd0);
    check("idle_out_data", 32'(out_data), 32'd0);
    tick();

    // Reset while stalled; counters are left non-zero beforehand.
    issue(OP_BUND, 2'd0, 4'd0);
    out_ready = 1'b0;
    store(2'd3, 1'b0, 16'hC0FC);
    store(2'd3, 1'b1, 16'hC0FC);
    @(negedge clk);
    check("pre_rst_stall", 32'(inst_ready), 32'd0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst_cycle_inst_ready", 32'(inst_ready), 32'd0);
    tick();
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    store(2'd0, 1'b0, 16'h0000);
    issue(OP_LOAD, 2'd1, 4'd8);
    issue(OP_MAJ,  2'd1, 4'd2);
    store(2'd1, 1'b0, 16'h0000);
    issue(OP_LOAD, 2'd0, 4'd3);
    store(2'd0, 1'b1, 16'h8001);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hv_core_multi.md
HV_CORE_MULTI -- requirements
Module: hv_core_multi

Interface
REQ-001 The block SHALL take parameter D, default 1024, meaning the hypervector width in bits.
REQ-002 The block SHALL take parameter ADDR_W, default 10, meaning the item-memory address width, with depth 2**ADDR_W.
REQ-003 The block SHALL take parameter NREG, default 4, meaning the register-file entry count, fixed at 4 because register selects are 2-bit.
REQ-004 The block SHALL take parameter SHIFT, default 1, meaning the rotate distance for permute operations, with 1 <= SHIFT < D.
REQ-005 The block SHALL take parameter CNT_W, default 8, meaning the width of each signed bundling counter.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 The block SHALL have ports gen, update_item (input, 1 bit each), item_a (input, ADDR_W bits) and rand_num (input, D bits); item_memory[item_a] <= rand_num when gen & update_item.
REQ-009 The block SHALL have ports inst_valid (input, 1 bit), inst (input, 16 bits) and inst_ready (output, 1 bit): the instruction valid/ready handshake.
REQ-010 The block SHALL have ports out_valid, out_last (output, 1 bit each), out_data (output, D bits) and out_ready (input, 1 bit): the result valid/ready handshake.

Function
REQ-011 Instruction fields SHALL be: op=inst[15:12], rd=inst[11:10], rs=inst[1:0], addr=inst[ADDR_W-1:0].
REQ-012 Opcodes SHALL be: 0 NOP; 1 LOAD rd=M[addr]; 2 LROR rd=ror(M[addr]); 3 LROL rd=rol(M[addr]); 4 LXOR rd^=M[addr]; 5 ROR rd=ror(rd); 6 ROL rd=rol(rd); 7 XOR rd^=r[rs]; 8 MOVE rd=r[rs]; 9 BUND; 10 MAJ; 11 CLR; 12 STORE; 13 LASTORE; 14-15 treated as NOP.
REQ-013 Rotates SHALL be by SHIFT bits; ror moves bit SHIFT to bit 0, and rol moves bit 0 to bit SHIFT.
REQ-014 The block SHALL have a 2-stage pipeline: S1 is handshake acceptance plus a registered item-memory read at addr; S2 executes, with register, counter and output updates taking effect at the end of S2.
REQ-015 An instruction accepted in cycle t SHALL have its results visible in cycle t+2, so back-to-back dependent instructions execute at 1 per cycle without bubbles.
REQ-016 BUND SHALL update each counter c[i] by +1 if r[rd][i]=1 and -1 otherwise, saturating at +(2**(CNT_W-1)-1) and -(2**(CNT_W-1)-1).
REQ-017 MAJ SHALL set rd[i] to 1 if c[i]>0, to 0 if c[i]<0, and to r[rs][i] if c[i]=0; the counters are left unchanged.
REQ-018 CLR SHALL zero all counters.
REQ-019 STORE SHALL load out_data=r[rd] and set out_valid=1 and out_last=0; LASTORE SHALL do the same but with out_last=1.
REQ-020 out_valid, out_data and out_last SHALL hold stable until out_valid & out_ready, then clear to 0 the next cycle unless a new STORE or LASTORE is executing that cycle.
REQ-021 The block SHALL stall when S2 holds STORE or LASTORE while out_valid=1 and out_ready=0: S2 holds and inst_ready=0.
REQ-022 inst_ready SHALL equal ~rst & ~gen & ~stall.
REQ-023 S1 SHALL hold its instruction while S2 is stalled, and the memory read data SHALL be held alongside it.
REQ-024 An item-memory write SHALL take priority and SHALL never collide with an instruction read, because inst_ready=0 during gen.
REQ-025 Register and counter writes from the same S2 instruction SHALL be single-destination, so no simultaneous-write conflict exists.

Reset
REQ-026 On rst, the register file, counters, S1/S2 valid flags, out_valid, out_last and out_data SHALL all be cleared to 0.
REQ-027 The item memory SHALL NOT be reset.
REQ-028 A reset asserted mid-stall SHALL discard in-flight instructions and any pending output, and no handshake SHALL complete in the reset cycle.

Structure
REQ-029 Package hv_pkg SHALL hold the opcode enum, the instruction field positions and a saturating-counter width helper.
REQ-030 The item memory SHALL be inferred as block RAM with a 1-cycle registered read.
REQ-031 One sub-module, hv_bundle_acc, SHALL hold the D counters and perform the BUND, CLR and MAJ compare.

Verification (D=16, SHIFT=1, CNT_W=4)
REQ-032 Write M[3]=0x8001, issue LOAD r0,3 then STORE r0 with out_ready=1 -> out_valid=1 with out_data=0x8001 and out_last=0, 3 cycles after LOAD acceptance.
REQ-033 Load 0x0001 into r0, then ROR r0 -> r0=0x8000; ROL twice -> r0=0x0002.
REQ-034 BUND 0xFFFF, 0x00FF and 0x0F0F, then MAJ r1 with rs=r2=0x0000 -> r1=0x0FFF.
REQ-035 Issue 9 BUNDs of 0xFFFF, then MAJ -> all counters saturate at +7 and r=0xFFFF.
REQ-036 Issue STORE with out_ready=0 for 5 cycles, then LASTORE -> inst_ready=0 throughout, out_data stable, then LASTORE output with out_last=1 after the first handshake.
REQ-037 Assert rst while stalled -> out_valid=0 next cycle, registers=0, and M contents preserved.
